// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, registers ROM data for decode,
// redirects through a loadable branch-target LUT and flags the halt opcode.
// Optional cycle counter output is built when FETCH_CYCLE_COUNT_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; outputs sit at their reset values
// RUN     | fetching one instruction per unstalled cycle
// HALTED  | halt opcode seen; done held high until the next start
module fetch_unit #(
  parameter int                 PC_W       = 10,
  parameter int                 INSTR_W    = 9,
  parameter int                 LUT_AW     = 5,
  parameter logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [LUT_AW-1:0]  target_idx,
  input  logic               lut_we,
  input  logic [LUT_AW-1:0]  lut_widx,
  input  logic [PC_W-1:0]    lut_wdata,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  output logic               done
`ifdef FETCH_CYCLE_COUNT_EN
  ,
  output logic [31:0]        cycle_count
`endif
);

  localparam int LUT_N = 2 ** LUT_AW;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic [PC_W-1:0]    lut_q [LUT_N];
  logic [PC_W-1:0]    lut_d [LUT_N];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < LUT_N; i++) lut_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      lut_q   <= lut_d;
    end
  end

  // LUT lookups read lut_q, so a same-cycle write to that index returns the old entry.
  always_comb begin
    lut_d = lut_q;
    if (lut_we) lut_d[lut_widx] = lut_wdata;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    done_d  = done_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = '0;
          valid_d = 1'b0;
          done_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (stall) begin
          // whole stage frozen
        end else if (branch_taken) begin
          pc_d    = lut_q[target_idx];
          valid_d = 1'b0;
        end else if (instr_in == HALT_INSTR) begin
          state_d = ST_HALTED;
          done_d  = 1'b1;
          valid_d = 1'b0;
        end else begin
          instr_d = instr_in;
          valid_d = 1'b1;
          pc_d    = pc_q + PC_W'(1);
        end
      end
      ST_HALTED: begin
        valid_d = 1'b0;
        if (start) begin
          state_d = ST_RUN;
          pc_d    = '0;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = '0;
        valid_d = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  assign pc          = pc_q;
  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign done        = done_q;

`ifdef FETCH_CYCLE_COUNT_EN
  logic [31:0] cnt_q, cnt_d;

  // Counts every RUN cycle including stalls; saturates rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_RUN) begin
      if (cnt_q != '1) cnt_d = cnt_q + 32'd1;
    end else if (start) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cycle_count = cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand sequences
// for branch/stall/wrap/reset corners, then random traffic against a model.
module tb_fetch_unit;
  localparam logic [8:0] HALT = 9'h1FF;

  logic       clk = 1'b0;
  logic       reset, start, stall, branch_taken, lut_we;
  logic [4:0] target_idx, lut_widx;
  logic [9:0] lut_wdata;
  logic [8:0] instr_in;
  logic [9:0] pc;
  logic [8:0] instr_out;
  logic       instr_valid, done;
`ifdef FETCH_CYCLE_COUNT_EN
  logic [31:0] cycle_count;
`endif

  logic [8:0] rom [1024];
  assign instr_in = rom[pc];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .branch_taken(branch_taken), .target_idx(target_idx),
    .lut_we(lut_we), .lut_widx(lut_widx), .lut_wdata(lut_wdata),
    .instr_in(instr_in), .pc(pc), .instr_out(instr_out),
    .instr_valid(instr_valid), .done(done)
`ifdef FETCH_CYCLE_COUNT_EN
    , .cycle_count(cycle_count)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference model: 0 idle, 1 running, 2 halted
  int         m_state = 0;
  int         m_pc = 0;
  logic [8:0] m_instr = '0;
  logic       m_valid = 1'b0;
  logic       m_done = 1'b0;
  int         m_lut [32];
  longint     m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    int old_tgt;
    if (reset) begin
      m_state = 0; m_pc = 0; m_instr = '0; m_valid = 1'b0; m_done = 1'b0; m_cnt = 0;
      for (int i = 0; i < 32; i++) m_lut[i] = 0;
      return;
    end
    old_tgt = m_lut[target_idx];
    if (m_state == 0) begin
      if (start) begin m_state = 1; m_pc = 0; m_valid = 1'b0; m_done = 1'b0; m_cnt = 0; end
    end else if (m_state == 1) begin
      if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (stall) begin
      end else if (branch_taken) begin
        m_pc = old_tgt; m_valid = 1'b0;
      end else if (rom[m_pc] == HALT) begin
        m_state = 2; m_done = 1'b1; m_valid = 1'b0;
      end else begin
        m_instr = rom[m_pc]; m_valid = 1'b1; m_pc = (m_pc + 1) % 1024;
      end
    end else begin
      m_valid = 1'b0;
      if (start) begin m_state = 1; m_pc = 0; m_done = 1'b0; m_cnt = 0; end
    end
    if (lut_we) m_lut[lut_widx] = lut_wdata;
  endtask

  task automatic check_all(input string name);
    chk({name, "_pc"}, 32'(pc), 32'(m_pc));
    chk({name, "_instr"}, 32'(instr_out), 32'(m_instr));
    chk({name, "_valid"}, 32'(instr_valid), 32'(m_valid));
    chk({name, "_done"}, 32'(done), 32'(m_done));
`ifdef FETCH_CYCLE_COUNT_EN
    chk({name, "_cnt"}, cycle_count, 32'(m_cnt));
`endif
  endtask

  task automatic tick(input string name);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(name);
  endtask

  task automatic clr_inputs();
    reset = 1'b0; start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    target_idx = '0; lut_we = 1'b0; lut_widx = '0; lut_wdata = '0;
  endtask

  typedef struct {
    logic        rst, st, stl, br;
    logic [9:0]  e_pc;
    logic [8:0]  e_instr;
    logic        e_valid, e_done;
    logic [31:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic rst, st, stl, br, input logic [9:0] p,
                              input logic [8:0] i, input logic v, d, input logic [31:0] c);
    vec_t r;
    r.rst = rst; r.st = st; r.stl = stl; r.br = br;
    r.e_pc = p; r.e_instr = i; r.e_valid = v; r.e_done = d; r.e_cnt = c;
    return r;
  endfunction

  vec_t vecs [13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
  end

  initial begin
    for (int i = 0; i < 32; i++) m_lut[i] = 0;
    for (int i = 0; i < 1024; i++) rom[i] = 9'((i * 7 + 3) % 509);
    rom[0] = 9'h001; rom[1] = 9'h002; rom[2] = 9'h003; rom[3] = HALT;
    clr_inputs();

    // Run to halt, linger, restart from halted, run to halt again
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 9'h000, 1'b0, 1'b0, 32'd0);
    vecs[1]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 9'h000, 1'b0, 1'b0, 32'd0);
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 10'd1, 9'h001, 1'b1, 1'b0, 32'd1);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 10'd2, 9'h002, 1'b1, 1'b0, 32'd2);
    vecs[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 10'd3, 9'h003, 1'b1, 1'b0, 32'd3);
    vecs[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 10'd3, 9'h003, 1'b0, 1'b1, 32'd4);
    vecs[6]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 10'd3, 9'h003, 1'b0, 1'b1, 32'd4);
    vecs[7]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 10'd3, 9'h003, 1'b0, 1'b1, 32'd4);
    vecs[8]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 9'h003, 1'b0, 1'b0, 32'd0);
    vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 10'd1, 9'h001, 1'b1, 1'b0, 32'd1);
    vecs[10] = mk(1'b0, 1'b0, 1'b0, 1'b0, 10'd2, 9'h002, 1'b1, 1'b0, 32'd2);
    vecs[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 10'd3, 9'h003, 1'b1, 1'b0, 32'd3);
    vecs[12] = mk(1'b0, 1'b0, 1'b0, 1'b0, 10'd3, 9'h003, 1'b0, 1'b1, 32'd4);

    for (int k = 0; k < 13; k++) begin
      reset = vecs[k].rst; start = vecs[k].st; stall = vecs[k].stl; branch_taken = vecs[k].br;
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk($sformatf("vec%0d_pc", k), 32'(pc), 32'(vecs[k].e_pc));
      chk($sformatf("vec%0d_instr", k), 32'(instr_out), 32'(vecs[k].e_instr));
      chk($sformatf("vec%0d_valid", k), 32'(instr_valid), 32'(vecs[k].e_valid));
      chk($sformatf("vec%0d_done", k), 32'(done), 32'(vecs[k].e_done));
`ifdef FETCH_CYCLE_COUNT_EN
      chk($sformatf("vec%0d_cnt", k), cycle_count, vecs[k].e_cnt);
`endif
    end
    clr_inputs();

    // Branch through preloaded LUT; same-cycle write to that index returns the old target
    reset = 1'b1; tick("s2_rst"); reset = 1'b0;
    lut_we = 1'b1; lut_widx = 5'd4; lut_wdata = 10'd20; tick("s2_lut"); lut_we = 1'b0;
    start = 1'b1; tick("s2_start"); start = 1'b0;
    tick("s2_f0"); tick("s2_f1");
    chk("s2_pre_instr", 32'(instr_out), 32'h002);
    branch_taken = 1'b1; target_idx = 5'd4;
    lut_we = 1'b1; lut_widx = 5'd4; lut_wdata = 10'd50;
    tick("s2_br");
    branch_taken = 1'b0; lut_we = 1'b0;
    chk("s2_br_pc", 32'(pc), 32'd20);
    chk("s2_br_valid", 32'(instr_valid), 32'd0);
    chk("s2_br_hold", 32'(instr_out), 32'h002);
    tick("s2_tgt");
    chk("s2_tgt_instr", 32'(instr_out), 32'(rom[20]));
    chk("s2_tgt_pc", 32'(pc), 32'd21);
    branch_taken = 1'b1; tick("s2_br2"); branch_taken = 1'b0;
    chk("s2_newlut_pc", 32'(pc), 32'd50);

    // Stall at pc=5 with a live instruction; branch during stall is ignored
    lut_we = 1'b1; lut_widx = 5'd1; lut_wdata = 10'd4; tick("s3_lut"); lut_we = 1'b0;
    branch_taken = 1'b1; target_idx = 5'd1; tick("s3_br"); branch_taken = 1'b0;
    tick("s3_f4");
    chk("s3_pc5", 32'(pc), 32'd5);
    stall = 1'b1; branch_taken = 1'b1; target_idx = 5'd4;
    for (int k = 0; k < 3; k++) begin
      tick("s3_stall");
      chk("s3_stall_pc", 32'(pc), 32'd5);
      chk("s3_stall_instr", 32'(instr_out), 32'(rom[4]));
      chk("s3_stall_valid", 32'(instr_valid), 32'd1);
    end
    stall = 1'b0; branch_taken = 1'b0;
    tick("s3_rel");
    chk("s3_rel_instr", 32'(instr_out), 32'(rom[5]));
    chk("s3_rel_pc", 32'(pc), 32'd6);

    // PC wraps from all ones to zero
    lut_we = 1'b1; lut_widx = 5'd2; lut_wdata = 10'd1022; tick("s4_lut"); lut_we = 1'b0;
    branch_taken = 1'b1; target_idx = 5'd2; tick("s4_br"); branch_taken = 1'b0;
    chk("s4_pc1022", 32'(pc), 32'd1022);
    tick("s4_w1"); chk("s4_pc1023", 32'(pc), 32'd1023);
    tick("s4_w2"); chk("s4_pc0", 32'(pc), 32'd0);
    tick("s4_w3"); chk("s4_pc1", 32'(pc), 32'd1);

    // Mid-run reset clears the LUT; start in RUN is ignored
    lut_we = 1'b1; lut_widx = 5'd3; lut_wdata = 10'd7; tick("s5_lut"); lut_we = 1'b0;
    branch_taken = 1'b1; target_idx = 5'd3; tick("s5_br"); branch_taken = 1'b0;
    chk("s5_pc7", 32'(pc), 32'd7);
    reset = 1'b1; tick("s5_rst"); reset = 1'b0;
    chk("s5_rst_pc", 32'(pc), 32'd0);
    chk("s5_rst_valid", 32'(instr_valid), 32'd0);
    chk("s5_rst_done", 32'(done), 32'd0);
    tick("s5_idle");
    chk("s5_idle_pc", 32'(pc), 32'd0);
    start = 1'b1; tick("s5_start"); start = 1'b0;
    tick("s5_f0");
    branch_taken = 1'b1; target_idx = 5'd3; tick("s5_br2"); branch_taken = 1'b0;
    chk("s5_lutclr_pc", 32'(pc), 32'd0);
    tick("s5_f0b");
    start = 1'b1; tick("s5_runstart"); start = 1'b0;
    chk("s5_runstart_pc", 32'(pc), 32'd2);

    // Random traffic against the reference model
    for (int i = 0; i < 1024; i++)
      rom[i] = ($urandom_range(0, 29) == 0) ? HALT : 9'($urandom_range(0, 510));
    reset = 1'b1; tick("rnd_rst"); reset = 1'b0;
    for (int n = 0; n < 600; n++) begin
      reset        = ($urandom_range(0, 99) == 0);
      start        = ($urandom_range(0, 9) == 0);
      stall        = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 6) == 0);
      target_idx   = 5'($urandom);
      lut_we       = ($urandom_range(0, 3) == 0);
      lut_widx     = 5'($urandom);
      lut_wdata    = 10'($urandom);
      tick("rnd");
    end
    clr_inputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end of the ISA demo core.
- Owns the program counter and addresses the combinational instruction ROM.
- Registers each fetched instruction for the decode stage and redirects the PC on taken branches through a loadable branch-target lookup table.
- Detects the halt instruction and raises done, which the core's top level exports for the simulation bench.

Parameters:
- PC_W, 10, program counter / ROM address width
- INSTR_W, 9, instruction width
- LUT_AW, 5, branch-target LUT index width (2**LUT_AW entries of PC_W bits)
- HALT_INSTR, 9'h1FF, encoding that terminates execution

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse, begins execution from PC 0
- stall  in  1  decode back-pressure; freezes the fetch stage
- branch_taken  in  1  decode resolved a taken branch for the instruction currently in instr_out
- target_idx  in  LUT_AW  LUT index of the branch target
- lut_we  in  1  LUT write enable
- lut_widx  in  LUT_AW  LUT write index
- lut_wdata  in  PC_W  LUT write data
- instr_in  in  INSTR_W  ROM read data for address pc, same cycle
- pc  out  PC_W  ROM address
- instr_out  out  INSTR_W  registered instruction to decode
- instr_valid  out  1  instr_out is a live instruction
- done  out  1  halt reached

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state=IDLE, pc=0, instr_out=0, instr_valid=0, done=0, all LUT entries=0. reset overrides every other input in the same cycle, including mid-run.
- FSM states: IDLE, RUN, HALTED.
- IDLE:
  - outputs hold their reset values.
  - start → RUN with pc=0.
- RUN, priority from high to low:
  1. stall=1: pc, instr_out and instr_valid hold; branch_taken and instr_in are ignored.
  2. branch_taken=1: pc ← LUT[target_idx]; instr_valid ← 0, which squashes the wrong-path instruction at pc; instr_out holds.
  3. instr_in==HALT_INSTR: state → HALTED; done ← 1; instr_valid ← 0; pc holds at the halt address. The halt instruction is never presented to decode.
  4. Otherwise: instr_out ← instr_in; instr_valid ← 1; pc ← pc+1, wrapping modulo 2**PC_W (pc at all ones goes to 0).
- Latency: an instruction at address A appears on instr_out one cycle after pc==A is sampled without stall.
- HALTED:
  - done stays 1; pc and instr_out hold; instr_valid=0.
  - start → RUN with pc=0, done=0.
  - stall and branch_taken are ignored.
- start while in RUN is ignored.
- LUT writes:
  - Honoured in every state (used for preload before start).
  - Write data is visible to a branch lookup on the following cycle.
  - A simultaneous write and lookup to the same index returns the old value.
- All arithmetic is unsigned and PC_W wide; no sign extension.

Optional Feature:
- Macro: FETCH_CYCLE_COUNT_EN.
- Defined:
  - Adds output cycle_count, 32 bits.
  - Cleared to 0 on reset and on the start that enters RUN.
  - Increments on every RUN cycle, stalled cycles included; saturates at all ones.
  - Freezes in IDLE and HALTED.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
1. Reset, then start; ROM holds 9'h001, 9'h002, 9'h003 at 0–2 and HALT at 3 → instr_out 001/002/003 with instr_valid=1 on cycles 1/2/3 after start; done=1 from cycle 4; pc stays 3.
2. Preload LUT[4]=10'd20; assert branch_taken with target_idx=4 while instr_out=9'h002 → next cycle pc=20, instr_valid=0; the following cycle instr_out=ROM[20].
3. Assert stall for 3 cycles at pc=5 → pc=5, instr_out and instr_valid unchanged for 3 cycles; branch_taken asserted during the stall has no effect.
4. Preset pc near 1023 with a ROM without HALT at 1022–1023 → pc sequence 1022, 1023, 0, 1.
5. Assert reset at pc=7 in RUN → next cycle state IDLE, pc=0, instr_valid=0, done=0; the LUT is cleared.
6. After HALTED, pulse start → done=0 next cycle, pc=0, re-execution matches scenario 1. With FETCH_CYCLE_COUNT_EN defined, scenario 1 ends with cycle_count=4.
